// File: rtl/pixel_frame_writer.sv
// rtl/pixel_frame_writer.sv - assembles R,G,B nibbles into 12-bit pixels and stores them in a frame buffer
// Optional GRAYSCALE_EN stores a replicated 4-bit gray value instead of raw RGB.
module pixel_frame_writer #(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        data_pack,
  input  logic              pack_valid,
  input  logic              frame_ack,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [11:0]       rd_data,
  output logic              rd_valid,
  output logic              wr_pulse,
  output logic [ADDR_W:0]   pix_count,
  output logic              frame_done,
  output logic              overflow
);

  localparam int                DEPTH     = IMG_W * IMG_H;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {S_R, S_G, S_B, S_DONE} state_t;

  state_t            state, state_next;
  logic              prev_valid;
  logic              accept;
  logic [3:0]        r_reg, g_reg;
  logic [ADDR_W-1:0] wr_addr;
  logic              latch_r, latch_g, do_write, do_rearm, drop;
  logic [11:0]       wr_word;
  logic [11:0]       mem [DEPTH];

  // prev_valid resets high so a level already asserted at reset release is ignored
  assign accept     = pack_valid & ~prev_valid;
  assign frame_done = (state == S_DONE);

`ifdef GRAYSCALE_EN
  logic [5:0] gray;
  assign gray    = (6'(r_reg) + {1'b0, g_reg, 1'b0} + 6'(data_pack)) >> 2;
  assign wr_word = {gray[3:0], gray[3:0], gray[3:0]};
`else
  assign wr_word = {r_reg, g_reg, data_pack};
`endif

  always_comb begin
    state_next = state;
    latch_r    = 1'b0;
    latch_g    = 1'b0;
    do_write   = 1'b0;
    do_rearm   = 1'b0;
    drop       = 1'b0;
    case (state)
      S_R: if (accept) begin
        latch_r    = 1'b1;
        state_next = S_G;
      end
      S_G: if (accept) begin
        latch_g    = 1'b1;
        state_next = S_B;
      end
      S_B: if (accept) begin
        do_write   = 1'b1;
        state_next = (wr_addr == LAST_ADDR) ? S_DONE : S_R;
      end
      S_DONE: begin
        drop = accept;
        if (frame_ack) begin
          do_rearm   = 1'b1;
          state_next = S_R;
        end
      end
      default: state_next = S_R;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_R;
      prev_valid <= 1'b1;
      r_reg      <= 4'h0;
      g_reg      <= 4'h0;
      wr_addr    <= '0;
      pix_count  <= '0;
      wr_pulse   <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_next;
      prev_valid <= pack_valid;
      wr_pulse   <= do_write;
      if (latch_r) r_reg <= data_pack;
      if (latch_g) g_reg <= data_pack;
      if (drop) overflow <= 1'b1;
      // the last address holds until re-armed so wr_addr never wraps
      if (do_write) begin
        if (wr_addr != LAST_ADDR) wr_addr <= wr_addr + 1'b1;
        pix_count <= pix_count + 1'b1;
      end
      if (do_rearm) begin
        wr_addr   <= '0;
        pix_count <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) mem[wr_addr] <= wr_word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data  <= 12'h000;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= ({1'b0, rd_addr} < DEPTH_CNT) ? mem[rd_addr] : 12'h000;
    end
  end

endmodule

// File: tb/tb_pixel_frame_writer.sv
// tb/tb_pixel_frame_writer.sv - self-checking bench for pixel_frame_writer
// Build with +define+GRAYSCALE_EN to check the grayscale variant.
module tb_pixel_frame_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  data_pack;
  logic        pack_valid;
  logic        frame_ack;
  logic        rd_en;
  logic [5:0]  rd_addr;
  logic [11:0] rd_data;
  logic        rd_valid;
  logic        wr_pulse;
  logic [6:0]  pix_count;
  logic        frame_done;
  logic        overflow;

  int checks = 0;
  int fails  = 0;
  logic [11:0] sb[$];

  typedef struct {
    logic [3:0]  r, g, b;
    logic [11:0] word;
  } vec_t;
  vec_t vecs[64];

  pixel_frame_writer #(.IMG_W(8), .IMG_H(8), .ADDR_W(6)) dut (
    .clk(clk), .reset(reset), .data_pack(data_pack), .pack_valid(pack_valid),
    .frame_ack(frame_ack), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .wr_pulse(wr_pulse), .pix_count(pix_count),
    .frame_done(frame_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] model(input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
`ifdef GRAYSCALE_EN
    int s;
    logic [3:0] q;
    s = (int'(r) + 2 * int'(g) + int'(b)) / 4;
    q = s[3:0];
    return {q, q, q};
`else
    return {r, g, b};
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_nib(input logic [3:0] d, output logic wp);
    data_pack  = d;
    pack_valid = 1'b1;
    @(negedge clk);
    wp = wr_pulse;
    pack_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_pix(input logic [3:0] r, input logic [3:0] g, input logic [3:0] b,
                          output logic [2:0] wps);
    send_nib(r, wps[2]);
    send_nib(g, wps[1]);
    send_nib(b, wps[0]);
  endtask

  task automatic read_at(input logic [5:0] addr, input logic [11:0] exp);
    rd_en   = 1'b1;
    rd_addr = addr;
    sb.push_back(exp);
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rd_valid) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL rd_valid_unexpected: got 1 expected 0");
      end else begin
        chk("rd_data", {20'h0, rd_data}, {20'h0, sb.pop_front()});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] wps;
    logic       wp;
    reset = 1'b1; data_pack = 4'h0; pack_valid = 1'b1; frame_ack = 1'b0;
    rd_en = 1'b0; rd_addr = '0;

    for (int i = 0; i < 64; i++) begin
      vecs[i].r    = 4'(i);
      vecs[i].g    = ~4'(i);
      vecs[i].b    = 4'h1;
      vecs[i].word = model(vecs[i].r, vecs[i].g, vecs[i].b);
    end

    // reset with pack_valid already high: must not be taken as a nibble
    repeat (3) @(negedge clk);
    chk("reset_outputs", {rd_data, rd_valid, wr_pulse, pix_count, frame_done, overflow}, 32'h0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    pack_valid = 1'b0;
    @(negedge clk);

    send_pix(4'hA, 4'h5, 4'h3, wps);
    chk("first_pix_wr_pulse", 32'(wps), 32'b001);
    chk("first_pix_count", 32'(pix_count), 32'd1);
    read_at(6'd0, model(4'hA, 4'h5, 4'h3));
    #1 chk("first_read_drained", 32'(sb.size()), 32'd0);

    // long level counts once
    data_pack = 4'h7; pack_valid = 1'b1;
    repeat (5) @(negedge clk);
    pack_valid = 1'b0;
    @(negedge clk);
    send_nib(4'h2, wps[1]);
    send_nib(4'h9, wps[0]);
    chk("held_level_wr_pulse", 32'(wps[1:0]), 32'b01);
    chk("held_level_count", 32'(pix_count), 32'd2);
    read_at(6'd1, model(4'h7, 4'h2, 4'h9));
    @(negedge clk);
    chk("rd_hold_valid", 32'(rd_valid), 32'd0);
    chk("rd_hold_data", 32'(rd_data), 32'(model(4'h7, 4'h2, 4'h9)));

    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // full frame from the vector table
    for (int i = 0; i < 64; i++) begin
      send_pix(vecs[i].r, vecs[i].g, vecs[i].b, wps);
      chk($sformatf("frame_wr_pulse_%0d", i), 32'(wps), 32'b001);
      chk($sformatf("frame_done_%0d", i), 32'(frame_done), 32'(i == 63));
    end
    chk("frame_count", 32'(pix_count), 32'd64);
    for (int i = 0; i < 64; i++) read_at(6'(i), vecs[i].word);
    #1 chk("frame_read_drained", 32'(sb.size()), 32'd0);

    // overflow while full
    send_nib(4'hF, wp);
    chk("drop_wr_pulse", 32'(wp), 32'd0);
    chk("drop_overflow", 32'(overflow), 32'd1);
    chk("drop_count", 32'(pix_count), 32'd64);
    chk("drop_frame_done", 32'(frame_done), 32'd1);

    // ack together with a nibble: nibble dropped, writer re-armed
    frame_ack = 1'b1; data_pack = 4'hE; pack_valid = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0; pack_valid = 1'b0;
    @(negedge clk);
    chk("ack_frame_done", 32'(frame_done), 32'd0);
    chk("ack_count", 32'(pix_count), 32'd0);
    chk("ack_overflow_sticky", 32'(overflow), 32'd1);

    // stray ack mid-pixel is ignored
    send_nib(4'h8, wps[2]);
    frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
    send_nib(4'h4, wps[1]);
    send_nib(4'hC, wps[0]);
    chk("rearm_wr_pulse", 32'(wps), 32'b001);
    chk("rearm_count", 32'(pix_count), 32'd1);
    read_at(6'd0, model(4'h8, 4'h4, 4'hC));
    read_at(6'd1, vecs[1].word);
    read_at(6'd63, vecs[63].word);
    @(negedge clk);
    chk("rd_addr_63_64", 32'(rd_data), 32'(vecs[63].word));

    // reset mid-pixel 5
    for (int i = 1; i < 5; i++) send_pix(4'(i), 4'h2, 4'h3, wps);
    chk("pre_reset_count", 32'(pix_count), 32'd5);
    send_nib(4'hE, wp);
    send_nib(4'hF, wp);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_reset_outputs", {wr_pulse, pix_count, frame_done, overflow}, 32'h0);
    send_pix(4'h1, 4'h2, 4'h3, wps);
    chk("post_reset_wr_pulse", 32'(wps), 32'b001);
    chk("post_reset_count", 32'(pix_count), 32'd1);
    read_at(6'd0, model(4'h1, 4'h2, 4'h3));
    read_at(6'd4, model(4'h4, 4'h2, 4'h3));
    read_at(6'd5, vecs[5].word);
    @(negedge clk);
    #1 chk("final_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
